// File: rtl/reg_file.sv
// Integer register file x0..x31: one WB write port and two combinational ID read ports.
// Define REGFILE_BYPASS_EN to let a same-cycle WB write appear on the read ports.
module reg_file #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int IDX_W   = 5    // 2**IDX_W must equal REG_NUM
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             we_in,
  input  logic [IDX_W-1:0] wIdx_in,
  input  logic [XLEN-1:0]  wData_in,
  input  logic             re1_in,
  input  logic [IDX_W-1:0] rIdx1_in,
  output logic [XLEN-1:0]  rData1_out,
  input  logic             re2_in,
  input  logic [IDX_W-1:0] rIdx2_in,
  output logic [XLEN-1:0]  rData2_out
);

  logic [XLEN-1:0] regs [REG_NUM];

  // NOTE: the storage array is deliberately inside the async reset, so no entry can ever
  // read back X, even one that is never written; this costs a flop-based array, not a RAM.
  // NOTE: non-blocking assignments keep every entry update tied to the same clock edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      regs <= '{default: '0};
    end else if (we_in && (wIdx_in != '0)) begin
      regs[wIdx_in] <= wData_in;
    end
  end

  // Read priority: reset, port disabled, x0, same-cycle WB bypass, stored entry.
  // The x0 test sits ahead of the bypass, so a write to x0 can never be forwarded.
  function automatic logic [XLEN-1:0] read_port(input logic             re,
                                                 input logic [IDX_W-1:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (rst_in || !re || (idx == '0)) begin
      val = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we_in && (wIdx_in == idx)) begin
      val = wData_in;
`endif
    end else begin
      val = regs[idx];
    end
    return val;
  endfunction

  // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    rData1_out = read_port(re1_in, rIdx1_in);
    rData2_out = read_port(re2_in, rIdx2_in);
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read data, a negedge monitor checks it.
// Expectations follow REGFILE_BYPASS_EN the same way the design does.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in;
  logic        rst_in;
  logic        we_in;
  logic [4:0]  wIdx_in;
  logic [31:0] wData_in;
  logic        re1_in;
  logic [4:0]  rIdx1_in;
  logic [31:0] rData1_out;
  logic        re2_in;
  logic [4:0]  rIdx2_in;
  logic [31:0] rData2_out;

  reg_file #(.XLEN(32), .REG_NUM(32), .IDX_W(5)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .we_in     (we_in),
    .wIdx_in   (wIdx_in),
    .wData_in  (wData_in),
    .re1_in    (re1_in),
    .rIdx1_in  (rIdx1_in),
    .rData1_out(rData1_out),
    .re2_in    (re2_in),
    .rIdx2_in  (rIdx2_in),
    .rData2_out(rData2_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int errors  = 0;

  string       name_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] exp2_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: outputs are combinational, so one pending expectation is checked per negedge.
  initial begin
    string       n;
    logic [31:0] e1;
    logic [31:0] e2;
    forever begin
      @(negedge clk_in);
      if (name_q.size() != 0) begin
        n  = name_q.pop_front();
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        check({n, "/rd1"}, rData1_out, e1);
        check({n, "/rd2"}, rData2_out, e2);
      end
    end
  end

  task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
    name_q.push_back(name);
    exp1_q.push_back(e1);
    exp2_q.push_back(e2);
  endtask

  task automatic drive(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                       input logic r1e, input logic [4:0] r1,
                       input logic r2e, input logic [4:0] r2);
    we_in    = we;
    wIdx_in  = wi;
    wData_in = wd;
    re1_in   = r1e;
    rIdx1_in = r1;
    re2_in   = r2e;
    rIdx2_in = r2;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    next_cycle();
    expect_rd("reset_state", 32'h0, 32'h0);
    next_cycle();
    rst_in = 1'b0;

    // Write x5; port 1 reads the same index in the write cycle.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd6);
    expect_rd("wr_x5", BYP ? 32'hDEADBEEF : 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    expect_rd("rd_x5", 32'hDEADBEEF, 32'hDEADBEEF);

    // Asynchronous reset raised mid-cycle must zero the outputs before any edge.
    next_cycle();
    #1;
    rst_in = 1'b1;
    expect_rd("async_rst", 32'h0, 32'h0);
    next_cycle();
    rst_in = 1'b0;
    expect_rd("x5_cleared", 32'h0, 32'h0);

    // Basic write with both read ports disabled, then read back on port 1 only.
    next_cycle();
    drive(1'b1, 5'd10, 32'h12345678, 1'b0, 5'd10, 1'b0, 5'd10);
    expect_rd("re_off_bypass", 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b0, 5'd10);
    expect_rd("rd_x10", 32'h12345678, 32'h0);

    // x0 hardwire: a write to x0 is neither stored nor forwarded.
    next_cycle();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    expect_rd("x0_wr_cycle", 32'h0, 32'h0);
    next_cycle();
    drive(1'b1, 5'd7, 32'h00000001, 1'b1, 5'd0, 1'b1, 5'd0);
    expect_rd("x0_after", 32'h0, 32'h0);

    // Both ports hit the same-cycle write to x7 (x7 currently holds 1).
    next_cycle();
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 1'b1, 5'd7);
    expect_rd("dual_bypass", BYP ? 32'hA5A5A5A5 : 32'h00000001,
                             BYP ? 32'hA5A5A5A5 : 32'h00000001);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    expect_rd("x7_after", 32'hA5A5A5A5, 32'hA5A5A5A5);

    // Independent ports while an unrelated write is in flight.
    next_cycle();
    drive(1'b1, 5'd12, 32'h000000C3, 1'b1, 5'd10, 1'b1, 5'd7);
    expect_rd("indep_ports", 32'h12345678, 32'hA5A5A5A5);
    next_cycle();
    drive(1'b1, 5'd13, 32'hCAFEF00D, 1'b1, 5'd12, 1'b1, 5'd13);
    expect_rd("port2_bypass", 32'h000000C3, BYP ? 32'hCAFEF00D : 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 1'b1, 5'd12);
    expect_rd("rd_x13_x12", 32'hCAFEF00D, 32'h000000C3);

    // Index compare must use all bits: x15 and x31 differ only in the MSB.
    next_cycle();
    drive(1'b1, 5'd31, 32'h80000001, 1'b1, 5'd15, 1'b1, 5'd31);
    expect_rd("idx_msb_wr", 32'h0, BYP ? 32'h80000001 : 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd15);
    expect_rd("idx_msb_rd", 32'h80000001, 32'h0);

    // Reset and write on the same edge: reset wins.
    next_cycle();
    rst_in = 1'b1;
    drive(1'b1, 5'd3, 32'h00000055, 1'b1, 5'd3, 1'b1, 5'd3);
    expect_rd("rst_wr_cycle", 32'h0, 32'h0);
    next_cycle();
    rst_in = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd10);
    expect_rd("rst_wr_after", 32'h0, 32'h0);

    // First write after reset release is taken on the next edge.
    next_cycle();
    drive(1'b1, 5'd3, 32'h00000055, 1'b1, 5'd7, 1'b1, 5'd31);
    expect_rd("regs_cleared", 32'h0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd0);
    expect_rd("post_rst_wr", 32'h00000055, 32'h0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20; i++) begin
      if (name_q.size() == 0) break;
      @(negedge clk_in);
      #1;
    end
    if (name_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", name_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
